// File: rtl/alu_ctrl_decoder.sv
// Registered RV32-subset decode stage feeding the ALU, with a one-entry skid buffer and
// branch-resolution handshake back to fetch.
//
// state   | meaning
// RUN     | normal issue, in_ready follows skid occupancy
// BR_WAIT | branch issued to EX, issue blocked until ex_br_done
module alu_ctrl_decoder #(
   parameter int ILL_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          instr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2:0]           aluOp,
   output logic                 useImm,
   output logic [31:0]          imm,
   output logic [4:0]           rs1,
   output logic [4:0]           rs2,
   output logic [4:0]           rd,
   output logic                 regWrite,
   output logic                 memRead,
   output logic                 memWrite,
   output logic                 isBranch,
   input  logic                 ex_br_done,
   input  logic                 aluZero,
   output logic                 br_valid,
   output logic                 br_taken,
   output logic [ILL_CNT_W-1:0] ill_cnt
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_BNE = 3'b110;
   localparam logic [2:0] OP_BEQ = 3'b111;

   typedef enum logic {RUN = 1'b0, BR_WAIT = 1'b1} state_t;

   typedef struct packed {
      logic [2:0]  alu_op;
      logic        use_imm;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        is_branch;
   } bundle_t;

   state_t                 state_q, state_d;
   bundle_t                out_q, out_d, skid_q, skid_d, dec;
   logic                   out_valid_q, out_valid_d;
   logic                   skid_valid_q, skid_valid_d;
   logic                   br_valid_q, br_valid_d;
   logic                   br_taken_q, br_taken_d;
   logic [ILL_CNT_W-1:0]   ill_cnt_q, ill_cnt_d;
   logic                   dec_legal;
   logic                   in_ready_c;
   logic                   accept;
   logic                   out_free;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_sh;

   assign opc    = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_sh = {27'b0, instr[24:20]};

   // Register fields a format does not use are driven as zero.
   always_comb begin
      dec       = '0;
      dec_legal = 1'b0;
      case (opc)
         7'b0110011: begin
            dec.rs1       = instr[19:15];
            dec.rs2       = instr[24:20];
            dec.rd        = instr[11:7];
            dec.reg_write = 1'b1;
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'b000:  begin dec.alu_op = OP_ADD; dec_legal = 1'b1; end
                  3'b111:  begin dec.alu_op = OP_AND; dec_legal = 1'b1; end
                  3'b110:  begin dec.alu_op = OP_OR;  dec_legal = 1'b1; end
                  3'b001:  begin dec.alu_op = OP_SLL; dec_legal = 1'b1; end
                  default: dec_legal = 1'b0;
               endcase
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
               dec.alu_op = OP_SUB;
               dec_legal  = 1'b1;
            end else if (f7 == 7'b0000001 && f3 == 3'b000) begin
               dec.alu_op = OP_MUL;
               dec_legal  = 1'b1;
            end
         end
         7'b0010011: begin
            dec.rs1       = instr[19:15];
            dec.rd        = instr[11:7];
            dec.use_imm   = 1'b1;
            dec.reg_write = 1'b1;
            dec.imm       = imm_i;
            case (f3)
               3'b000:  begin dec.alu_op = OP_ADD; dec_legal = 1'b1; end
               3'b111:  begin dec.alu_op = OP_AND; dec_legal = 1'b1; end
               3'b110:  begin dec.alu_op = OP_OR;  dec_legal = 1'b1; end
               3'b001: begin
                  dec.alu_op = OP_SLL;
                  dec.imm    = imm_sh;
                  dec_legal  = (f7 == 7'b0000000);
               end
               default: dec_legal = 1'b0;
            endcase
         end
         7'b0000011: begin
            dec.alu_op    = OP_ADD;
            dec.rs1       = instr[19:15];
            dec.rd        = instr[11:7];
            dec.use_imm   = 1'b1;
            dec.imm       = imm_i;
            dec.mem_read  = 1'b1;
            dec.reg_write = 1'b1;
            dec_legal     = (f3 == 3'b010);
         end
         7'b0100011: begin
            dec.alu_op    = OP_ADD;
            dec.rs1       = instr[19:15];
            dec.rs2       = instr[24:20];
            dec.use_imm   = 1'b1;
            dec.imm       = imm_s;
            dec.mem_write = 1'b1;
            dec_legal     = (f3 == 3'b010);
         end
         7'b1100011: begin
            dec.rs1       = instr[19:15];
            dec.rs2       = instr[24:20];
            dec.imm       = imm_b;
            dec.is_branch = 1'b1;
            dec.alu_op    = (f3 == 3'b001) ? OP_BNE : OP_BEQ;
            dec_legal     = (f3 == 3'b000) || (f3 == 3'b001);
         end
         default: dec_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // A done pulse only resolves a branch already waiting; a new branch handshake re-arms the wait.
   always_comb begin
      state_d = state_q;
      if (state_q == BR_WAIT && ex_br_done)
         state_d = RUN;
      if (out_valid_q && out_ready && out_q.is_branch)
         state_d = BR_WAIT;
   end

   always_comb begin
      in_ready_c = !skid_valid_q && (state_q == RUN);
      br_valid_d = (state_q == BR_WAIT) && ex_br_done;
      br_taken_d = (state_q == BR_WAIT) && ex_br_done && aluZero;
   end

   assign accept   = in_valid && in_ready_c;
   assign out_free = !out_valid_q || out_ready;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      ill_cnt_d    = ill_cnt_q;
      if (out_free) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept && dec_legal) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept && dec_legal) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
      if (accept && !dec_legal && ill_cnt_q != {ILL_CNT_W{1'b1}})
         ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         ill_cnt_q    <= '0;
         br_valid_q   <= 1'b0;
         br_taken_q   <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         ill_cnt_q    <= ill_cnt_d;
         br_valid_q   <= br_valid_d;
         br_taken_q   <= br_taken_d;
      end
   end

   assign in_ready  = in_ready_c;
   assign out_valid = out_valid_q;
   assign aluOp     = out_q.alu_op;
   assign useImm    = out_q.use_imm;
   assign imm       = out_q.imm;
   assign rs1       = out_q.rs1;
   assign rs2       = out_q.rs2;
   assign rd        = out_q.rd;
   assign regWrite  = out_q.reg_write;
   assign memRead   = out_q.mem_read;
   assign memWrite  = out_q.mem_write;
   assign isBranch  = out_q.is_branch;
   assign br_valid  = br_valid_q;
   assign br_taken  = br_taken_q;
   assign ill_cnt   = ill_cnt_q;

endmodule
